// File: rtl/dmem_pkg.sv
// Shared types and helpers for the clocked RV32 data memory.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   function automatic logic is_legal(input logic we, input logic [2:0] funct3);
      if (we) return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
      return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
             (funct3 == F3_BU) || (funct3 == F3_HU);
   endfunction

   // Illegal codes fall into the 4-byte bucket; they are rejected separately.
   function automatic logic [2:0] access_bytes(input logic [2:0] funct3);
      case (funct3[1:0])
         2'b00:   return 3'd1;
         2'b01:   return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/dmem_load_format.sv
// Assembles raw memory bytes into sign/zero-extended load data.
module dmem_load_format
   import dmem_pkg::*;
#(
   parameter int unsigned BIG_ENDIAN = 1
) (
   input  logic [31:0] raw_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] rdata_c_o
);

   logic [7:0]  b0, b1, b2, b3;
   logic [15:0] half;
   logic [31:0] word;

   // raw_i byte k is the byte at address+k.
   always_comb begin
      b0   = raw_i[7:0];
      b1   = raw_i[15:8];
      b2   = raw_i[23:16];
      b3   = raw_i[31:24];
      half = (BIG_ENDIAN != 0) ? {b0, b1} : {b1, b0};
      word = (BIG_ENDIAN != 0) ? {b0, b1, b2, b3} : {b3, b2, b1, b0};
      case (funct3_i)
         F3_B:    rdata_c_o = {{24{b0[7]}}, b0};
         F3_H:    rdata_c_o = {{16{half[15]}}, half};
         F3_W:    rdata_c_o = word;
         F3_BU:   rdata_c_o = {24'd0, b0};
         F3_HU:   rdata_c_o = {16'd0, half};
         default: rdata_c_o = 32'd0;
      endcase
   end

endmodule

// File: rtl/dmem_sync.sv
// Clocked byte-addressed RV32 data memory with valid/ready request and response channels.
module dmem_sync
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_BYTES = 128,
   parameter int unsigned WAIT_STATES = 0,
   parameter int unsigned BIG_ENDIAN  = 1,
   parameter int unsigned ALIGN_CHECK = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned AW = $clog2(DEPTH_BYTES);

   state_t         state_q, state_d;
   logic [3:0]     cnt_q, cnt_d;
   logic           we_q;
   logic [2:0]     f3_q;
   logic [31:0]    addr_q, wdata_q;
   logic           req_ready_q, rsp_valid_q, rsp_err_q;
   logic [31:0]    rsp_rdata_q;
   logic [7:0]     mem_q [DEPTH_BYTES];

   logic           accept, commit;
   logic           c_we;
   logic [2:0]     c_f3;
   logic [31:0]    c_addr, c_wdata;
   logic [2:0]     nbytes;
   logic [AW:0]    last;
   logic           err;
   logic [AW-1:0]  idx [4];
   logic [31:0]    be_word, raw, load_data;
   logic [7:0]     wbyte [4];
   logic [3:0]     wen;

   assign accept    = (state_q == IDLE) && req_valid;
   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

   // Next state; commit marks the edge that enters RESP.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      commit  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               cnt_d = 4'd0;
               if (WAIT_STATES == 0) begin
                  state_d = RESP;
                  commit  = 1'b1;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'(WAIT_STATES - 1)) begin
               state_d = RESP;
               commit  = 1'b1;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // With no wait states the commit uses the request being accepted this cycle.
   always_comb begin
      c_we    = (state_q == IDLE) ? req_we     : we_q;
      c_f3    = (state_q == IDLE) ? req_funct3 : f3_q;
      c_addr  = (state_q == IDLE) ? req_addr   : addr_q;
      c_wdata = (state_q == IDLE) ? req_wdata  : wdata_q;
      nbytes  = access_bytes(c_f3);
      last    = {1'b0, c_addr[AW-1:0]} + (AW+1)'(nbytes - 3'd1);
      err     = !is_legal(c_we, c_f3) || (c_addr[31:AW] != '0) || last[AW] ||
                ((ALIGN_CHECK != 0) &&
                 (((nbytes == 3'd2) && c_addr[0]) ||
                  ((nbytes == 3'd4) && (c_addr[1:0] != 2'b00))));
      // Left-justify the stored bytes so lane 0 receives the MSB in big-endian mode.
      be_word = c_wdata << (6'd32 - {nbytes, 3'b000});
      for (int k = 0; k < 4; k++) begin
         idx[k]           = c_addr[AW-1:0] + AW'(k);
         wen[k]           = 3'(k) < nbytes;
         wbyte[k]         = (BIG_ENDIAN != 0) ? be_word[8*(3-k) +: 8] : c_wdata[8*k +: 8];
         raw[8*k +: 8]    = mem_q[idx[k]];
      end
   end

   dmem_load_format #(.BIG_ENDIAN(BIG_ENDIAN)) u_fmt (
      .raw_i     (raw),
      .funct3_i  (c_f3),
      .rdata_c_o (load_data)
   );

   // Byte array; reset seeds byte i with its own address.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH_BYTES); i++) mem_q[i] <= 8'(i);
      end else if (commit && c_we && !err) begin
         for (int k = 0; k < 4; k++) if (wen[k]) mem_q[idx[k]] <= wbyte[k];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         we_q        <= 1'b0;
         f3_q        <= 3'd0;
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'd0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         req_ready_q <= (state_d == IDLE);
         rsp_valid_q <= (state_d == RESP);
         if (accept) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
         if (commit) begin
            rsp_err_q   <= err;
            rsp_rdata_q <= (err || c_we) ? 32'd0 : load_data;
         end
      end
   end

endmodule

// File: tb/tb_dmem_sync.sv
// Directed self-checking bench for dmem_sync across four parameter sets.
module tb_dmem_sync;
   import dmem_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_ready;
   logic        req_valid [4];
   logic        req_ready [4];
   logic        rsp_valid [4];
   logic        rsp_err   [4];
   logic [31:0] rsp_rdata [4];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dmem_sync #(.WAIT_STATES(0), .BIG_ENDIAN(1)) u0 (
      .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));
   dmem_sync #(.WAIT_STATES(0), .BIG_ENDIAN(0)) u1 (
      .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));
   dmem_sync #(.WAIT_STATES(2), .BIG_ENDIAN(1)) u2 (
      .clk(clk), .reset(reset), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
      .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]));
   dmem_sync #(.WAIT_STATES(3), .BIG_ENDIAN(1)) u3 (
      .clk(clk), .reset(reset), .req_valid(req_valid[3]), .req_ready(req_ready[3]),
      .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid[3]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata[3]), .rsp_err(rsp_err[3]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // One transaction on DUT d; hold>0 stalls rsp_ready and checks the response stays put.
   task automatic txn(input int d, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd, input int hold,
                      output logic [31:0] rd, output logic er, output int lat);
      int n;
      req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      req_valid[d] = 1'b1;
      n = 0;
      while (!req_ready[d] && n < 50) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      req_valid[d] = 1'b0;
      req_wdata = ~wd;
      lat = 1;
      while (!rsp_valid[d] && lat < 50) begin
         chk("busy_req_ready", 32'(req_ready[d]), 32'd0);
         @(posedge clk); #1; lat++;
      end
      rd = rsp_rdata[d];
      er = rsp_err[d];
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         chk("hold_rsp_valid", 32'(rsp_valid[d]), 32'd1);
         chk("hold_req_ready", 32'(req_ready[d]), 32'd0);
         chk("hold_rdata", rsp_rdata[d], rd);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("rsp_dropped", 32'(rsp_valid[d]), 32'd0);
   endtask

   logic [31:0] rd;
   logic        er;
   int          lat;
   logic [31:0] bb_wd [8];
   int          idx, nresp, cyc, last_acc;
   logic        acc;

   initial begin
      for (int i = 0; i < 4; i++) req_valid[i] = 1'b0;
      req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'd0; req_wdata = 32'd0;
      rsp_ready = 1'b0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      chk("reset_req_ready", 32'(req_ready[0]), 32'd1);
      chk("reset_rsp_valid", 32'(rsp_valid[0]), 32'd0);
      chk("reset_rsp_rdata", rsp_rdata[0], 32'd0);
      chk("reset_rsp_err", 32'(rsp_err[0]), 32'd0);

      txn(0, 1'b0, F3_W, 32'h04, 32'd0, 0, rd, er, lat);
      chk("lw04_be", rd, 32'h04050607);
      chk("lw04_be_err", 32'(er), 32'd0);
      chk("lw04_lat", 32'(lat), 32'd1);
      txn(1, 1'b0, F3_W, 32'h04, 32'd0, 0, rd, er, lat);
      chk("lw04_le", rd, 32'h07060504);

      txn(0, 1'b1, F3_B, 32'h10, 32'h00000080, 0, rd, er, lat);
      chk("sb10_rdata", rd, 32'd0);
      chk("sb10_err", 32'(er), 32'd0);
      txn(0, 1'b0, F3_B, 32'h10, 32'd0, 0, rd, er, lat);
      chk("lb10", rd, 32'hFFFFFF80);
      txn(0, 1'b0, F3_BU, 32'h10, 32'd0, 0, rd, er, lat);
      chk("lbu10", rd, 32'h00000080);
      txn(0, 1'b0, F3_W, 32'h10, 32'd0, 0, rd, er, lat);
      chk("lw10", rd, 32'h80111213);
      txn(0, 1'b0, F3_H, 32'h10, 32'd0, 0, rd, er, lat);
      chk("lh10", rd, 32'hFFFF8011);

      txn(0, 1'b0, F3_H, 32'h03, 32'd0, 0, rd, er, lat);
      chk("lh03_err", 32'(er), 32'd1);
      chk("lh03_rdata", rd, 32'd0);
      chk("lh03_lat", 32'(lat), 32'd1);
      txn(0, 1'b1, F3_W, 32'h7E, 32'hAABBCCDD, 0, rd, er, lat);
      chk("sw7e_err", 32'(er), 32'd1);
      txn(0, 1'b0, F3_BU, 32'h7E, 32'd0, 0, rd, er, lat);
      chk("mem7e_kept", rd, 32'h0000007E);
      txn(0, 1'b0, F3_BU, 32'h7F, 32'd0, 0, rd, er, lat);
      chk("mem7f_kept", rd, 32'h0000007F);
      txn(0, 1'b0, F3_W, 32'h80, 32'd0, 0, rd, er, lat);
      chk("lw80_err", 32'(er), 32'd1);
      chk("lw80_rdata", rd, 32'd0);
      txn(0, 1'b0, 3'b011, 32'h00, 32'd0, 0, rd, er, lat);
      chk("ld_f3_011_err", 32'(er), 32'd1);
      txn(0, 1'b1, F3_BU, 32'h00, 32'h000000FF, 0, rd, er, lat);
      chk("st_f3_100_err", 32'(er), 32'd1);
      txn(0, 1'b0, F3_BU, 32'h00, 32'd0, 0, rd, er, lat);
      chk("mem00_kept", rd, 32'd0);

      txn(1, 1'b1, F3_H, 32'h30, 32'h1234BEEF, 0, rd, er, lat);
      txn(1, 1'b0, F3_HU, 32'h30, 32'd0, 0, rd, er, lat);
      chk("le_sh_lhu", rd, 32'h0000BEEF);
      txn(1, 1'b0, F3_BU, 32'h30, 32'd0, 0, rd, er, lat);
      chk("le_lowbyte", rd, 32'h000000EF);

      txn(2, 1'b0, F3_HU, 32'h7E, 32'd0, 4, rd, er, lat);
      chk("lhu7e_rdata", rd, 32'h00007E7F);
      chk("lhu7e_err", 32'(er), 32'd0);
      chk("lhu7e_lat", 32'(lat), 32'd3);

      // Store on the 3-wait-state instance, then reset while it is still in WAIT.
      req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h20; req_wdata = 32'hDEADBEEF;
      req_valid[3] = 1'b1;
      @(posedge clk); #1;
      req_valid[3] = 1'b0;
      @(posedge clk); #1;
      chk("wait_req_ready", 32'(req_ready[3]), 32'd0);
      chk("wait_rsp_valid", 32'(rsp_valid[3]), 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("post_rst_ready", 32'(req_ready[3]), 32'd1);
      chk("post_rst_valid", 32'(rsp_valid[3]), 32'd0);
      txn(3, 1'b0, F3_W, 32'h20, 32'd0, 0, rd, er, lat);
      chk("lw20_after_rst", rd, 32'h20212223);
      chk("lw20_lat", 32'(lat), 32'd4);
      txn(0, 1'b0, F3_BU, 32'h10, 32'd0, 0, rd, er, lat);
      chk("mem_reinit", rd, 32'h00000010);

      // Back-to-back SW/LW pairs with req_valid held high.
      for (int i = 0; i < 8; i++) bb_wd[i] = {8'(i), 8'hC3, 8'h5A, 8'(8'h10 + i)};
      idx = 0; nresp = 0; cyc = 0; last_acc = 0;
      req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h40; req_wdata = bb_wd[0];
      req_valid[2] = 1'b1;
      rsp_ready = 1'b1;
      while (nresp < 8 && cyc < 200) begin
         if (rsp_valid[2]) begin
            if (((idx - 1) % 2) == 0) chk("bb_store_rdata", rsp_rdata[2], 32'd0);
            else                      chk("bb_load_rdata", rsp_rdata[2], bb_wd[idx-2]);
            chk("bb_err", 32'(rsp_err[2]), 32'd0);
            nresp++;
         end
         acc = req_ready[2] && req_valid[2];
         @(posedge clk); #1;
         cyc++;
         if (acc) begin
            if (idx > 0) chk("bb_spacing", 32'(cyc - last_acc), 32'd4);
            last_acc = cyc;
            idx++;
            if (idx < 8) begin
               req_we    = (idx % 2) == 0;
               req_addr  = 32'h40 + 32'(4 * (idx / 2));
               req_wdata = bb_wd[idx];
            end else begin
               req_valid[2] = 1'b0;
            end
         end
      end
      rsp_ready = 1'b0;
      chk("bb_accepts", 32'(idx), 32'd8);
      chk("bb_responses", 32'(nresp), 32'd8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmem_sync.md
Name: dmem_sync

Overview:
- Clocked, byte-addressed RV32 data memory that replaces the combinational data memory.
- Accepts one load or store per transaction over a valid/ready request channel and returns data or completion on a valid/ready response channel.
- Depth, wait-state latency and byte order are configurable.
- Misaligned, out-of-range and illegal-width accesses are flagged; they are never silently executed.
- Sits between the execute/memory pipeline stage and the load writeback path.

Parameters:
- DEPTH_BYTES, 128, memory size in bytes; power of two, 4 to 65536.
- WAIT_STATES, 0, extra cycles between request accept and response; 0 to 15.
- BIG_ENDIAN, 1, 1 = lowest address holds the MSB of a half or word; 0 = lowest address holds the LSB.
- ALIGN_CHECK, 1, 1 = misaligned half/word accesses report an error; 0 = they execute with byte addresses modulo DEPTH_BYTES.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, reset, asynchronous, active-high.
- req_valid, input, 1, request present.
- req_ready, output, 1, block can accept a request.
- req_we, input, 1, 1 = store, 0 = load.
- req_funct3, input, 3, RISC-V funct3 width/sign code.
- req_addr, input, 32, byte address.
- req_wdata, input, 32, store data; stored bytes are taken from the low bits.
- rsp_valid, output, 1, response present.
- rsp_ready, input, 1, consumer accepts the response.
- rsp_rdata, output, 32, formatted load data; 0 for stores and errors.
- rsp_err, output, 1, access fault.

Behaviour:
- Reset:
  - State goes to IDLE.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter cleared.
  - Every memory byte i is set to i[7:0].
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready the block captures we, funct3, addr and wdata.
  - Next state is WAIT if WAIT_STATES>0, otherwise RESP.
- WAIT:
  - req_ready=0; the counter counts WAIT_STATES cycles.
  - On the last count the block goes to RESP.
- RESP entry (commit edge):
  - Stores write the memory.
  - Loads register rsp_rdata.
  - rsp_err is registered.
- RESP:
  - rsp_valid=1 and req_ready=0.
  - rsp_rdata and rsp_err are held stable until rsp_ready=1.
  - Then the block returns to IDLE, with rsp_valid=0 on the next cycle.
- Timing:
  - Accept-to-rsp_valid latency is exactly 1+WAIT_STATES cycles.
  - Minimum spacing between accepts is 2+WAIT_STATES cycles; the block has no pipelining.
- Loads:
  - 000 LB: sign-extended byte.
  - 001 LH: sign-extended half.
  - 010 LW: full word.
  - 100 LBU: zero-extended byte.
  - 101 LHU: zero-extended half.
  - 011, 110, 111: illegal.
- Stores:
  - 000 SB, 001 SH, 010 SW.
  - All other codes are illegal.
  - Only the addressed bytes are written.
- rsp_err=1 when any of the following holds:
  - The funct3 code is illegal.
  - ALIGN_CHECK=1 and a half access has addr[0]=1.
  - ALIGN_CHECK=1 and a word access has addr[1:0]!=0.
  - The access touches any byte at or beyond DEPTH_BYTES (addr bits above log2(DEPTH_BYTES) nonzero, or last byte past the end).
- On an error the block writes nothing and returns rsp_rdata=0. The error response is timed exactly like a normal response.
- With ALIGN_CHECK=0, multi-byte accesses within range wrap their byte index modulo DEPTH_BYTES; this only matters at the top edge.
- Byte assembly follows BIG_ENDIAN for both loads and stores, so a store then a load of the same width returns the same value.
- Reset mid-transaction:
  - An uncommitted store (in WAIT) is dropped and memory is reinitialised.
  - A pending response is discarded.
  - The block is in IDLE with req_ready=1 on the first cycle after reset deasserts.
- Inputs are ignored outside the IDLE accept cycle. Changing req_wdata after accept has no effect.

Decomposition:
- Package dmem_pkg holds:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum: IDLE, WAIT, RESP.
  - Function is_legal(we, funct3).
  - Function access_bytes(funct3), returning 1, 2 or 4.
- Sub-module dmem_load_format: combinational; takes 4 raw bytes, funct3 and BIG_ENDIAN; returns the 32-bit extended rsp_rdata.
- The top level holds the FSM, wait counter, byte array, error logic and store byte-lane steering.

Test Plan:
- Reset, then LW addr 0x04, BIG_ENDIAN=1, WAIT_STATES=0 -> rsp_valid on cycle +1, rsp_rdata=0x04050607, rsp_err=0. With BIG_ENDIAN=0 -> 0x07060504.
- SB wdata 0x00000080 addr 0x10, then LB 0x10 -> 0xFFFFFF80; LBU 0x10 -> 0x00000080; LW 0x10 -> 0x80111213.
- LH addr 0x03 -> rsp_err=1, rsp_rdata=0. SW addr 0x7E -> rsp_err=1, bytes 0x7E and 0x7F unchanged. LW addr 0x80 -> rsp_err=1. Load funct3 011 -> rsp_err=1.
- WAIT_STATES=2: LHU addr 0x7E -> rsp_valid exactly 3 cycles after accept, rsp_rdata=0x00007E7F. Hold rsp_ready=0 for 4 cycles -> data stable, req_ready=0 throughout.
- WAIT_STATES=3: SW 0xDEADBEEF addr 0x20, assert reset during WAIT -> after reset, LW 0x20 returns 0x20212223.
- Back-to-back: req_valid held high with 8 alternating SW/LW at rising addresses and rsp_ready=1 -> accepts every 2+WAIT_STATES cycles and every LW returns the preceding SW's data.
